beta_irq_ctrl: RTL and testbench
================================

BETA_IRQ_CTRL -- requirements
Module: beta_irq_ctrl

Interface
REQ-001 The block SHALL have a parameter BASE, default 32'h0000_FF00, giving the byte address of a 32-byte register window; bits [4:0] are ignored.
REQ-002 The block SHALL have a parameter NSRC, default 8, giving the number of interrupt sources, in the range 1..8.
REQ-003 clk  in  1  the single clock; all state SHALL update on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 src  in  NSRC  interrupt request lines, asynchronous to clk.
REQ-006 ma  in  32  CPU memory address; bit 31 (supervisor) SHALL be ignored in decode.
REQ-007 mdout  in  32  CPU write data.
REQ-008 mwe  in  1  CPU write enable, valid in the same cycle as ma and mdout.
REQ-009 io_rdata  out  32  registered read data, for the top-level mdin mux.
REQ-010 io_sel  out  1  registered flag: io_rdata is valid this cycle and the top level SHALL route it to mdin.
REQ-011 irq  out  1  interrupt request to the CPU irq pin.
REQ-012 xadr  out  31  interrupt handler address to the CPU xadr pin.

Function
REQ-013 Hit SHALL be true when ma[30:5] == BASE[30:5].
REQ-014 Register map (byte offset ma[4:2]*4):
  - 0x00 PENDING: read; write-1-to-clear.
  - 0x04 ENABLE: read/write.
  - 0x08 EDGE: read/write; bit=1 selects rising-edge mode, bit=0 selects level mode.
  - 0x0C VECTOR: read/write; bits [4:0] and bit 31 SHALL read as 0.
  - 0x10 ACTIVE: read only; {valid, 28'b0, idx[2:0]}.
  - 0x14..0x1C: reserved; reads return 0, writes are ignored.
REQ-015 Register bits at positions >= NSRC SHALL read 0 and ignore writes.
REQ-016 Each src bit SHALL pass through a 2-flop synchronizer before any use.
REQ-017 In edge mode, a 0->1 transition of the synchronized src SHALL set PENDING[i] at the next edge.
REQ-018 In edge mode, if a set and a W1C of the same bit fall in the same cycle, set SHALL win.
REQ-019 In level mode, PENDING[i] SHALL equal the registered synchronized level, and W1C SHALL have no effect.
REQ-020 Switching EDGE[i] from 1 to 0 SHALL leave PENDING[i] to follow the level from the next cycle; switching from 0 to 1 SHALL clear PENDING[i] in the same edge as the write.
REQ-021 A CPU write SHALL take effect at the clock edge ending the cycle in which mwe && hit.
REQ-022 A CPU read SHALL be any hit cycle with !mwe: io_rdata <= selected register and io_sel <= 1 at that edge; otherwise io_sel <= 0.
REQ-023 Reads SHALL have no side effects.
REQ-024 A write cycle SHALL leave io_rdata unchanged.
REQ-025 irq SHALL equal |(PENDING & ENABLE), decoded from registers only (no path from ma, mdout or mwe).
REQ-026 idx SHALL be the lowest-numbered set bit of PENDING & ENABLE; bit 0 has highest priority.
REQ-027 xadr SHALL equal VECTOR[30:0] | (idx << 2).
REQ-028 When irq=0, xadr SHALL equal VECTOR[30:0].
REQ-029 Latency: src stable high from cycle 0 (edge or level mode, enabled) SHALL give irq=1 after the 3rd rising edge.
REQ-030 Latency: a W1C write clearing the last pending bit SHALL give irq=0 in the cycle after the write edge.

Reset
REQ-031 While reset=1 at an edge, the block SHALL set:
  - PENDING=0, ENABLE=0, EDGE=0
  - VECTOR=32'h0000_0100
  - synchronizers and edge-detect history = 0
  - io_rdata=0, io_sel=0
  - therefore irq=0 and xadr=31'h100
REQ-032 Reset asserted mid-access SHALL discard that access; a src already high when reset deasserts SHALL NOT register as an edge.

Structure
REQ-033 A shared package beta_irq_pkg SHALL hold the register offset constants, the NSRC maximum (8) and the VECTOR reset value.
REQ-034 The priority encoder SHALL be a sub-module irq_prio_enc (NSRC-bit input; idx[2:0] and valid outputs).
REQ-035 All other logic SHALL be in beta_irq_ctrl.

Verification
REQ-036 Reset, then read 0x0C: io_sel=1 one cycle later with io_rdata=32'h100; irq=0; xadr=31'h100.
REQ-037 Program ENABLE=8'h0C and EDGE=8'h04, then pulse src[2] for 1 cycle: irq=1 after 3 edges, xadr=31'h108, PENDING reads 8'h04; write 0x04 to PENDING: irq=0 next cycle.
REQ-038 Level src[3] high with ENABLE=8'h08: xadr=31'h10C; W1C of PENDING bit 3 leaves irq=1; src[3] low: irq=0 after 3 edges.
REQ-039 Both src[5] and src[1] pending and enabled: xadr selects idx 1 (31'h104) and ACTIVE reads 32'h8000_0001; clear bit 1: xadr=31'h114.
REQ-040 Same-cycle edge set and W1C on bit 2: PENDING[2] remains 1.
REQ-041 Write to 0x18 and an address outside the window: no register change and io_sel stays 0; assert reset during pending=8'hFF: all outputs return to reset values next cycle.

Source files
------------

// File: rtl/beta_irq_pkg.sv
// Shared constants for the beta interrupt controller.
// Register word offsets, source limit and VECTOR reset value.
package beta_irq_pkg;

   localparam int NSRC_MAX = 8;

   localparam logic [2:0] OFF_PENDING = 3'd0;
   localparam logic [2:0] OFF_ENABLE  = 3'd1;
   localparam logic [2:0] OFF_EDGE    = 3'd2;
   localparam logic [2:0] OFF_VECTOR  = 3'd3;
   localparam logic [2:0] OFF_ACTIVE  = 3'd4;

   localparam logic [31:0] VECTOR_RST = 32'h0000_0100;

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder for interrupt requests.
// Bit 0 wins; idx is 0 whenever nothing is requested.
module irq_prio_enc
   import beta_irq_pkg::*;
#(
   parameter int NSRC = NSRC_MAX
) (
   input  logic [NSRC-1:0] req_i,
   output logic [2:0]      idx_o,
   output logic            valid_o
);

   // scan high to low so the lowest set bit is the last to assign
   always_comb begin
      idx_o   = 3'd0;
      valid_o = 1'b0;
      for (int i = NSRC - 1; i >= 0; i--) begin
         if (req_i[i]) begin
            idx_o   = i[2:0];
            valid_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/beta_irq_ctrl.sv
// Memory-mapped interrupt controller with a 32-byte register window.
// Synchronises sources, latches pending bits, and drives irq/xadr.
module beta_irq_ctrl
   import beta_irq_pkg::*;
#(
   parameter logic [31:0] BASE = 32'h0000_FF00,
   parameter int          NSRC = 8
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [NSRC-1:0] src,
   input  logic [31:0]     ma,
   input  logic [31:0]     mdout,
   input  logic            mwe,
   output logic [31:0]     io_rdata,
   output logic            io_sel,
   output logic            irq,
   output logic [30:0]     xadr
);

   logic [NSRC-1:0] sync1_q;
   logic [NSRC-1:0] sync2_q;
   logic [NSRC-1:0] prev_q;
   logic [NSRC-1:0] pend_q;
   logic [NSRC-1:0] pend_d;
   logic [NSRC-1:0] en_q;
   logic [NSRC-1:0] edge_q;
   logic [30:5]     vec_q;
   logic [31:0]     rdata_q;
   logic [31:0]     rdata_d;
   logic            sel_q;

   logic            hit;
   logic            wr;
   logic            rd;
   logic [2:0]      off;
   logic            wr_pend;
   logic            wr_en;
   logic            wr_edge;
   logic            wr_vec;
   logic [NSRC-1:0] wdata;
   logic [NSRC-1:0] rise;
   logic [2:0]      idx;
   logic            valid;
   logic [31:0]     rd_mux;
   logic            unused_bits;

   assign hit     = (ma[30:5] == BASE[30:5]);
   assign wr      = hit & mwe;
   assign rd      = hit & ~mwe;
   assign off     = ma[4:2];
   assign wr_pend = wr & (off == OFF_PENDING);
   assign wr_en   = wr & (off == OFF_ENABLE);
   assign wr_edge = wr & (off == OFF_EDGE);
   assign wr_vec  = wr & (off == OFF_VECTOR);
   assign wdata   = mdout[NSRC-1:0];
   assign rise    = sync2_q & ~prev_q;

   assign unused_bits = ^{ma[31], ma[1:0], mdout};

   irq_prio_enc #(
      .NSRC (NSRC)
   ) u_prio (
      .req_i   (pend_q & en_q),
      .idx_o   (idx),
      .valid_o (valid)
   );

   // pending: sticky W1C latch in edge mode, registered level otherwise
   always_comb begin
      pend_d = pend_q;
      for (int i = 0; i < NSRC; i++) begin
         if (edge_q[i]) begin
            pend_d[i] = (pend_q[i] & ~(wr_pend & wdata[i])) | rise[i];
         end else if (wr_edge & wdata[i]) begin
            pend_d[i] = 1'b0;
         end else begin
            pend_d[i] = sync2_q[i];
         end
      end
   end

   // register read mux; reserved offsets read zero
   always_comb begin
      rd_mux = 32'h0;
      unique case (1'b1)
         (off == OFF_PENDING): rd_mux = 32'(pend_q);
         (off == OFF_ENABLE):  rd_mux = 32'(en_q);
         (off == OFF_EDGE):    rd_mux = 32'(edge_q);
         (off == OFF_VECTOR):  rd_mux = {1'b0, vec_q, 5'b0};
         (off == OFF_ACTIVE):  rd_mux = {valid, 28'b0, idx};
         default:              rd_mux = 32'h0;
      endcase
      rdata_d = rd ? rd_mux : rdata_q;
   end

   // all state, reset first so a colliding access is dropped
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
         prev_q  <= '0;
         pend_q  <= '0;
         en_q    <= '0;
         edge_q  <= '0;
         vec_q   <= VECTOR_RST[30:5];
         rdata_q <= 32'h0;
         sel_q   <= 1'b0;
      end else begin
         sync1_q <= src;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
         pend_q  <= pend_d;
         if (wr_en)   en_q   <= wdata;
         if (wr_edge) edge_q <= wdata;
         if (wr_vec)  vec_q  <= mdout[30:5];
         rdata_q <= rdata_d;
         sel_q   <= rd;
      end
   end

   assign io_rdata = rdata_q;
   assign io_sel   = sel_q;
   assign irq      = valid;
   assign xadr     = {vec_q, idx, 2'b00};

endmodule

// File: tb/tb_beta_irq_ctrl.sv
// Self-checking bench for beta_irq_ctrl.
// Directed scenarios followed by random traffic against a reference model.
module tb_beta_irq_ctrl;

   localparam int          NSRC = 8;
   localparam logic [31:0] BASE = 32'h0000_FF00;
   localparam logic [31:0] IDLE = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  src;
   logic [31:0] ma;
   logic [31:0] mdout;
   logic        mwe;
   logic [31:0] io_rdata;
   logic        io_sel;
   logic        irq;
   logic [30:0] xadr;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   beta_irq_ctrl #(
      .BASE (BASE),
      .NSRC (NSRC)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .src      (src),
      .ma       (ma),
      .mdout    (mdout),
      .mwe      (mwe),
      .io_rdata (io_rdata),
      .io_sel   (io_sel),
      .irq      (irq),
      .xadr     (xadr)
   );

   // reference state: src samples taken at the last three edges
   logic [7:0]  h [3];
   logic [7:0]  m_pend;
   logic [7:0]  m_en;
   logic [7:0]  m_edg;
   logic [31:0] m_vec;
   logic [31:0] m_rd;
   logic        m_sel;

   function automatic logic [2:0] lowest(input logic [7:0] v);
      for (int i = 0; i < 8; i++) begin
         if (v[i]) return 3'(i);
      end
      return 3'd0;
   endfunction

   function automatic logic [31:0] m_read(input logic [2:0] o);
      logic [7:0] a;
      a = m_pend & m_en;
      case (o)
         3'd0:    return {24'b0, m_pend};
         3'd1:    return {24'b0, m_en};
         3'd2:    return {24'b0, m_edg};
         3'd3:    return m_vec;
         3'd4:    return {|a, 28'b0, lowest(a)};
         default: return 32'h0;
      endcase
   endfunction

   task automatic model_edge();
      logic       hit;
      logic [2:0] o;
      logic [7:0] lvl;
      logic [7:0] rs;
      logic [7:0] np;
      if (reset) begin
         h[0] = 8'h0; h[1] = 8'h0; h[2] = 8'h0;
         m_pend = 8'h0; m_en = 8'h0; m_edg = 8'h0;
         m_vec = 32'h100; m_rd = 32'h0; m_sel = 1'b0;
      end else begin
         hit = (ma[30:5] == BASE[30:5]);
         o   = ma[4:2];
         lvl = h[1];
         rs  = h[1] & ~h[2];
         for (int i = 0; i < 8; i++) begin
            if (m_edg[i])
               np[i] = (m_pend[i] && !(hit && mwe && o == 3'd0 && mdout[i])) || rs[i];
            else if (hit && mwe && o == 3'd2 && mdout[i])
               np[i] = 1'b0;
            else
               np[i] = lvl[i];
         end
         m_sel = hit && !mwe;
         if (m_sel) m_rd = m_read(o);
         if (hit && mwe && o == 3'd1) m_en  = mdout[7:0];
         if (hit && mwe && o == 3'd2) m_edg = mdout[7:0];
         if (hit && mwe && o == 3'd3) m_vec = mdout & 32'h7FFF_FFE0;
         m_pend = np;
         h[2] = h[1]; h[1] = h[0]; h[0] = src;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      logic [7:0]  a;
      logic [30:0] ex;
      a  = m_pend & m_en;
      ex = m_vec[30:0] | ((|a) ? (31'(lowest(a)) << 2) : 31'h0);
      chk("irq", {31'b0, irq}, {31'b0, |a});
      chk("xadr", {1'b0, xadr}, {1'b0, ex});
      chk("io_sel", {31'b0, io_sel}, {31'b0, m_sel});
      chk("io_rdata", io_rdata, m_rd);
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_all();
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      ma = a; mdout = d; mwe = 1'b1;
      tick();
      mwe = 1'b0; ma = IDLE;
   endtask

   task automatic rd(input logic [31:0] a);
      ma = a; mwe = 1'b0;
      tick();
      ma = IDLE;
   endtask

   initial begin
      logic [31:0] ra;
      reset = 1'b1; src = 8'h0; ma = IDLE; mdout = 32'h0; mwe = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      chk("rst_irq", {31'b0, irq}, 32'h0);
      chk("rst_xadr", {1'b0, xadr}, 32'h100);
      chk("rst_sel", {31'b0, io_sel}, 32'h0);

      rd(BASE + 32'h0C);
      chk("vec_sel", {31'b0, io_sel}, 32'h1);
      chk("vec_rd", io_rdata, 32'h100);
      tick();
      chk("sel_drop", {31'b0, io_sel}, 32'h0);

      wr(BASE + 32'h04, 32'h0C);
      wr(BASE + 32'h08, 32'h04);
      src = 8'h04;
      tick();
      src = 8'h00;
      tick();
      chk("edge_lat2", {31'b0, irq}, 32'h0);
      tick();
      chk("edge_lat3", {31'b0, irq}, 32'h1);
      chk("edge_xadr", {1'b0, xadr}, 32'h108);
      rd(BASE + 32'h00);
      chk("edge_pend", io_rdata, 32'h04);
      wr(BASE + 32'h00, 32'h04);
      chk("w1c_irq", {31'b0, irq}, 32'h0);

      wr(BASE + 32'h04, 32'h08);
      src = 8'h08;
      tick(); tick(); tick();
      chk("lvl_irq", {31'b0, irq}, 32'h1);
      chk("lvl_xadr", {1'b0, xadr}, 32'h10C);
      wr(BASE + 32'h00, 32'h08);
      chk("lvl_w1c", {31'b0, irq}, 32'h1);
      src = 8'h00;
      tick(); tick();
      chk("lvl_hold", {31'b0, irq}, 32'h1);
      tick();
      chk("lvl_drop", {31'b0, irq}, 32'h0);

      wr(BASE + 32'h04, 32'h22);
      wr(BASE + 32'h08, 32'h22);
      src = 8'h22;
      tick();
      src = 8'h00;
      tick(); tick();
      chk("prio_xadr", {1'b0, xadr}, 32'h104);
      rd(BASE + 32'h10);
      chk("active", io_rdata, 32'h8000_0001);
      wr(BASE + 32'h00, 32'h02);
      chk("prio_next", {1'b0, xadr}, 32'h114);

      wr(BASE + 32'h08, 32'h26);
      src = 8'h04;
      tick();
      src = 8'h00;
      tick();
      wr(BASE + 32'h00, 32'h04);
      rd(BASE + 32'h00);
      chk("set_wins", io_rdata, 32'h24);

      wr(BASE + 32'h18, 32'hFFFF_FFFF);
      chk("rsv_sel", {31'b0, io_sel}, 32'h0);
      wr(32'h0001_0004, 32'hFF);
      chk("miss_sel", {31'b0, io_sel}, 32'h0);
      rd(BASE + 32'h04);
      chk("en_keep", io_rdata, 32'h22);
      rd(BASE + 32'h18);
      chk("rsv_rd", io_rdata, 32'h0);

      wr(BASE + 32'h08, 32'h00);
      wr(BASE + 32'h04, 32'hFF);
      src = 8'hFF;
      tick(); tick(); tick();
      rd(BASE + 32'h00);
      chk("all_pend", io_rdata, 32'hFF);
      ma = BASE + 32'h04; mdout = 32'h55; mwe = 1'b1; reset = 1'b1;
      tick();
      chk("mid_irq", {31'b0, irq}, 32'h0);
      chk("mid_xadr", {1'b0, xadr}, 32'h100);
      chk("mid_sel", {31'b0, io_sel}, 32'h0);
      chk("mid_rdata", io_rdata, 32'h0);
      reset = 1'b0; mwe = 1'b0; ma = IDLE; src = 8'h00;
      rd(BASE + 32'h04);
      chk("mid_discard", io_rdata, 32'h0);

      for (int n = 0; n < 400; n++) begin
         reset = ($urandom_range(0, 63) == 0);
         src   = 8'($urandom);
         mwe   = 1'($urandom_range(0, 1));
         mdout = $urandom;
         if ($urandom_range(0, 3) == 0) begin
            ma = $urandom;
         end else begin
            ra       = BASE;
            ra[31]   = 1'($urandom_range(0, 1));
            ra[4:0]  = 5'($urandom);
            ma       = ra;
         end
         tick();
      end
      reset = 1'b0; mwe = 1'b0; ma = IDLE;

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
